mux_select_scheduler: RTL and testbench

- Sequences the 3-bit video-source mux select from five front-panel buttons and a mode switch.
- Provides the following features:
  - per-button synchronisation and debounce;
  - priority arbitration of simultaneous presses;
  - an auto-rotate mode that cycles sources on a dwell timer;
  - a hold input that freezes the selection.
- Sits between the raw board inputs and the source mux; sel_out drives the mux select directly.

---
 rtl/mux_select_scheduler_pkg.sv | 17 +
 rtl/mux_select_scheduler_input_debounce.sv | 56 +++++
 rtl/mux_select_scheduler.sv | 127 ++++++++++++
 tb/tb_mux_select_scheduler.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_select_scheduler_pkg.sv
// Shared types and constants for the video-source select scheduler.
package mux_select_scheduler_pkg;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } state_e;

    localparam int unsigned SEL_DEFAULT = 0;
    localparam int unsigned SEL_FIRST   = 1;

    // Button i selects source code i+1; code 0 is the default source.
    function automatic int unsigned btn_code(input int unsigned idx);
        return idx + 1;
    endfunction

endpackage

// File: rtl/mux_select_scheduler_input_debounce.sv
// Two-flop synchroniser, consecutive-sample debouncer and registered edge pulses.
module input_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_prev_q;
    logic          rise_q;
    logic          fall_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            level_prev_q <= level_q;
            rise_q       <= level_q & ~level_prev_q;
            fall_q       <= ~level_q & level_prev_q;
            // Any sample matching the current level restarts the run.
            if (sync2_q != level_q) begin
                if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level_q <= sync2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/mux_select_scheduler.sv
// Video-source mux select sequencer: debounced buttons, priority pick, auto-rotate and hold.
module mux_select_scheduler
    import mux_select_scheduler_pkg::*;
#(
    parameter int unsigned NUM_SRC         = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned DWELL_CYCLES    = 1024,
    parameter int unsigned SEL_WIDTH       = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_SRC-1:0]   buttons,
    input  logic                 switch,
    input  logic                 hold,
    output logic [SEL_WIDTH-1:0] sel_out,
    output logic                 sel_changed,
    output logic                 auto_active
);

    localparam int unsigned DW = $clog2(DWELL_CYCLES + 1);

    logic [NUM_SRC-1:0] btn_level;
    logic [NUM_SRC-1:0] btn_rise;
    logic [NUM_SRC-1:0] btn_fall;
    logic               sw_level;
    logic               sw_rise;
    logic               sw_fall;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_btn
        input_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clock(clock),
            .reset(reset),
            .raw  (buttons[g]),
            .level(btn_level[g]),
            .rise (btn_rise[g]),
            .fall (btn_fall[g])
        );
    end

    input_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw (
        .clock(clock),
        .reset(reset),
        .raw  (switch),
        .level(sw_level),
        .rise (sw_rise),
        .fall (sw_fall)
    );

    // Levels and button releases carry no scheduling meaning.
    logic unused_sigs;
    assign unused_sigs = ^{btn_level, btn_fall, sw_level};

    logic                 press_any;
    logic [SEL_WIDTH-1:0] win_code;

    always_comb begin
        press_any = 1'b0;
        win_code  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (btn_rise[i]) begin
                press_any = 1'b1;
                win_code  = SEL_WIDTH'(btn_code(unsigned'(i)));
            end
        end
    end

    state_e               state_q, state_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d, sel_next;
    logic [DW-1:0]        dwell_q, dwell_d;

    assign sel_next = (sel_q >= SEL_WIDTH'(NUM_SRC)) ? SEL_WIDTH'(SEL_FIRST)
                                                     : sel_q + SEL_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        dwell_d = dwell_q;
        if (sw_rise) begin
            state_d = AUTO;
        end else if (sw_fall) begin
            state_d = MANUAL;
        end
        if (state_d == AUTO && state_q == MANUAL) begin
            dwell_d = '0;
        end
        if (!hold) begin
            if (state_d == AUTO) begin
                if (state_q == MANUAL) begin
                    sel_d = SEL_WIDTH'(SEL_FIRST);
                end else if (dwell_q == DW'(DWELL_CYCLES - 1)) begin
                    dwell_d = '0;
                    sel_d   = sel_next;
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            // Applied after the mode update so a press overrides entry and expiry.
            if (press_any) begin
                sel_d   = win_code;
                dwell_d = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= MANUAL;
            sel_q       <= SEL_WIDTH'(SEL_DEFAULT);
            dwell_q     <= '0;
            sel_changed <= 1'b0;
            auto_active <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            dwell_q     <= dwell_d;
            sel_changed <= (sel_d != sel_q);
            auto_active <= (state_d == AUTO);
        end
    end

    assign sel_out = sel_q;

endmodule

// File: tb/tb_mux_select_scheduler.sv
// Directed bench for mux_select_scheduler with short debounce and dwell settings.
module tb_mux_select_scheduler;

    logic       clock;
    logic       reset;
    logic [4:0] buttons;
    logic       switch;
    logic       hold;
    logic [2:0] sel_out;
    logic       sel_changed;
    logic       auto_active;

    int n_cmp;
    int n_bad;

    mux_select_scheduler #(
        .NUM_SRC        (5),
        .DEBOUNCE_CYCLES(4),
        .DWELL_CYCLES   (8),
        .SEL_WIDTH      (3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .buttons    (buttons),
        .switch     (switch),
        .hold       (hold),
        .sel_out    (sel_out),
        .sel_changed(sel_changed),
        .auto_active(auto_active)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        buttons = 5'b10101;
        switch  = 1'b0;
        hold    = 1'b0;
        tick(3);
        n_cmp++;
        if (sel_out !== 3'd0) begin
            n_bad++; $display("FAIL reset_sel: got %0d want 0", sel_out);
        end
        n_cmp++;
        if (sel_changed !== 1'b0) begin
            n_bad++; $display("FAIL reset_changed: got %0b want 0", sel_changed);
        end
        n_cmp++;
        if (auto_active !== 1'b0) begin
            n_bad++; $display("FAIL reset_auto: got %0b want 0", auto_active);
        end
        reset = 1'b1;
        tick(7);
        n_cmp++;
        if (sel_out !== 3'd0) begin
            n_bad++; $display("FAIL reset_early: got %0d want 0", sel_out);
        end
        tick(1);
        n_cmp++;
        if (sel_out !== 3'd1 || sel_changed !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_lowest_wins: got sel=%0d chg=%0b want sel=1 chg=1",
                     sel_out, sel_changed);
        end
        tick(1);
        n_cmp++;
        if (sel_changed !== 1'b0) begin
            n_bad++; $display("FAIL reset_pulse_width: got %0b want 0", sel_changed);
        end
    endtask

    task automatic test_bounce();
        int glitch;
        glitch  = 0;
        buttons = 5'b00000;
        tick(12);
        for (int t = 0; t < 10; t++) begin
            buttons[2] = ~buttons[2];
            for (int k = 0; k < 2; k++) begin
                tick(1);
                if (sel_out !== 3'd1 || sel_changed !== 1'b0) glitch++;
            end
        end
        n_cmp++;
        if (glitch != 0) begin
            n_bad++; $display("FAIL bounce_glitch: got %0d glitches want 0", glitch);
        end
        buttons[2] = 1'b1;
        tick(7);
        n_cmp++;
        if (sel_out !== 3'd1) begin
            n_bad++; $display("FAIL bounce_early: got %0d want 1", sel_out);
        end
        tick(1);
        n_cmp++;
        if (sel_out !== 3'd3 || sel_changed !== 1'b1) begin
            n_bad++;
            $display("FAIL bounce_accept: got sel=%0d chg=%0b want sel=3 chg=1",
                     sel_out, sel_changed);
        end
        tick(1);
        n_cmp++;
        if (sel_changed !== 1'b0) begin
            n_bad++; $display("FAIL bounce_single_pulse: got %0b want 0", sel_changed);
        end
    endtask

    task automatic test_simultaneous();
        int pulses;
        pulses  = 0;
        buttons = 5'b00000;
        tick(10);
        buttons = 5'b01010;
        tick(8);
        n_cmp++;
        if (sel_out !== 3'd2 || sel_changed !== 1'b1) begin
            n_bad++;
            $display("FAIL simul_priority: got sel=%0d chg=%0b want sel=2 chg=1",
                     sel_out, sel_changed);
        end
        buttons = 5'b00000;
        tick(10);
        buttons = 5'b00010;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (sel_changed !== 1'b0) pulses++;
        end
        n_cmp++;
        if (pulses != 0 || sel_out !== 3'd2) begin
            n_bad++;
            $display("FAIL simul_reselect: got sel=%0d pulses=%0d want sel=2 pulses=0",
                     sel_out, pulses);
        end
        buttons = 5'b00000;
        tick(10);
    endtask

    task automatic test_auto();
        int         glitch;
        logic [2:0] seq [5];
        logic [2:0] prev;
        seq[0] = 3'd2; seq[1] = 3'd3; seq[2] = 3'd4; seq[3] = 3'd5; seq[4] = 3'd1;
        switch = 1'b1;
        tick(7);
        n_cmp++;
        if (auto_active !== 1'b0 || sel_out !== 3'd2) begin
            n_bad++;
            $display("FAIL auto_early: got auto=%0b sel=%0d want auto=0 sel=2",
                     auto_active, sel_out);
        end
        tick(1);
        n_cmp++;
        if (sel_out !== 3'd1 || auto_active !== 1'b1 || sel_changed !== 1'b1) begin
            n_bad++;
            $display("FAIL auto_entry: got sel=%0d auto=%0b chg=%0b want 1 1 1",
                     sel_out, auto_active, sel_changed);
        end
        prev = 3'd1;
        for (int s = 0; s < 5; s++) begin
            glitch = 0;
            for (int k = 0; k < 7; k++) begin
                tick(1);
                if (sel_out !== prev) glitch++;
            end
            tick(1);
            n_cmp++;
            if (sel_out !== seq[s] || glitch != 0) begin
                n_bad++;
                $display("FAIL auto_rotate_%0d: got sel=%0d early=%0d want sel=%0d early=0",
                         s, sel_out, glitch, seq[s]);
            end
            prev = seq[s];
        end
        // Dwell counter is 0 here; press button 4 three cycles in.
        tick(3);
        buttons = 5'b10000;
        tick(5);
        n_cmp++;
        if (sel_out !== 3'd2) begin
            n_bad++; $display("FAIL auto_before_press: got %0d want 2", sel_out);
        end
        tick(3);
        n_cmp++;
        if (sel_out !== 3'd5) begin
            n_bad++; $display("FAIL auto_press_jump: got %0d want 5", sel_out);
        end
        tick(7);
        n_cmp++;
        if (sel_out !== 3'd5) begin
            n_bad++; $display("FAIL auto_dwell_restart: got %0d want 5", sel_out);
        end
        tick(1);
        n_cmp++;
        if (sel_out !== 3'd1) begin
            n_bad++; $display("FAIL auto_wrap_after_press: got %0d want 1", sel_out);
        end
        buttons = 5'b00000;
    endtask

    task automatic test_hold();
        int glitch;
        glitch = 0;
        tick(3);
        hold    = 1'b1;
        buttons = 5'b00001;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (sel_out !== 3'd1 || sel_changed !== 1'b0) glitch++;
        end
        n_cmp++;
        if (glitch != 0) begin
            n_bad++; $display("FAIL hold_frozen: got %0d changes want 0", glitch);
        end
        hold = 1'b0;
        tick(4);
        n_cmp++;
        if (sel_out !== 3'd1) begin
            n_bad++; $display("FAIL hold_resume_early: got %0d want 1", sel_out);
        end
        tick(1);
        n_cmp++;
        if (sel_out !== 3'd2 || auto_active !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_resume: got sel=%0d auto=%0b want sel=2 auto=1",
                     sel_out, auto_active);
        end
    endtask

    task automatic test_async_reset();
        tick(2);
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (sel_out !== 3'd0 || auto_active !== 1'b0 || sel_changed !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: got sel=%0d auto=%0b chg=%0b want 0 0 0",
                     sel_out, auto_active, sel_changed);
        end
        buttons = 5'b00000;
        switch  = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(12);
        n_cmp++;
        if (sel_out !== 3'd0 || auto_active !== 1'b0) begin
            n_bad++;
            $display("FAIL async_restart_manual: got sel=%0d auto=%0b want 0 0",
                     sel_out, auto_active);
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        reset   = 1'b0;
        buttons = 5'b00000;
        switch  = 1'b0;
        hold    = 1'b0;
        test_reset();
        test_bounce();
        test_simultaneous();
        test_auto();
        test_hold();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
